// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between several
// writeback sources, with a one-entry registered output slot and forwarding
// hit flags for the read-operand path.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          stall,
    output logic [ADDR_WIDTH-1:0]         wr_reg,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          reg_write,
    input  logic [ADDR_WIDTH-1:0]         rd_reg1,
    input  logic [ADDR_WIDTH-1:0]         rd_reg2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  slot_free;
    logic                  commit;
    logic                  gnt_valid;
    logic [PtrW-1:0]       gnt_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    // The slot can accept a new entry if it is empty or drains this cycle.
    assign slot_free = ~reg_write_q | ~stall;
    assign commit    = reg_write_q & ~stall;

    // Find the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!gnt_valid && req_valid[(32'(rr_ptr_q) + k) % NUM_REQ]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign transfer = gnt_valid & slot_free & ~reset;
    assign gnt_addr = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign gnt_data = req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    // One-hot ready toward the granted requester; silent during reset.
    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Slot and pointer next state: drain on commit, load on a non-zero-address grant.
    always_comb begin
        reg_write_d = reg_write_q;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (commit) begin
            reg_write_d = 1'b0;
        end
        if (transfer) begin
            rr_ptr_d = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            // Writes to register 0 are consumed but never reach the slot.
            if (gnt_addr != '0) begin
                reg_write_d = 1'b1;
                wr_reg_d    = gnt_addr;
                wr_data_d   = gnt_data;
            end
        end
    end

    // State registers with synchronous reset; a pending slot is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign reg_write = reg_write_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;

    // Register 0 never forwards; flags are forced low while reset is held.
    assign fwd_hit1 = ~reset & reg_write_q & (wr_reg_q == rd_reg1) & (rd_reg1 != '0);
    assign fwd_hit2 = ~reset & reg_write_q & (wr_reg_q == rd_reg2) & (rd_reg2 != '0);

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the CPU register file between several writeback sources (ALU, load unit, multiply/divide unit). Each source presents a valid/ready write request. The arbiter grants one request per cycle into a one-entry output stage that drives the register file's write address, data and enable. It honours the pipeline stall, drops writes to register 0, and exposes pending-write hit flags so the read-operand path can forward data.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  bit i: requester i has a write pending
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  packed; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  one-hot or zero; transfer on req_valid[i] & req_ready[i]
- stall  input  1  pipeline stall; register file ignores writes while high
- wr_reg  output  ADDR_WIDTH  write address to register file (registered)
- wr_data  output  DATA_WIDTH  write data to register file (registered)
- reg_write  output  1  write enable to register file (registered)
- rd_reg1, rd_reg2  input  ADDR_WIDTH each  current read addresses
- fwd_hit1, fwd_hit2  output  1 each  pending write targets rd_reg1 / rd_reg2

## Operation
- Output stage: one slot holding {wr_reg, wr_data}; reg_write is the slot-valid bit.
- Commit: the register file performs the write on an edge where reg_write & ~stall. The slot then frees.
- slot_free = ~reg_write | ~stall.
- Grant: when slot_free and any req_valid, assert req_ready for exactly one requester. Pick the first valid index at or after rr_ptr, scanning upward modulo NUM_REQ. Otherwise req_ready = 0.
- req_ready depends combinationally on req_valid and stall. Requesters must not derive req_valid from req_ready.
- On a transfer from requester g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If req_addr[g] != 0: load the slot; reg_write <= 1.
  - If req_addr[g] == 0: the request is consumed (dropped) and the slot is not loaded. reg_write <= 0 if the slot committed this cycle, else it is unchanged.
- No transfer and the slot commits: reg_write <= 0. wr_reg and wr_data hold their last values.
- Stall with an occupied slot: slot, rr_ptr and all outputs hold. No grants.
- Stall with an empty slot: a grant is allowed and loads the slot. Commit waits for the first non-stall cycle.
- Forwarding, combinational:
  - fwd_hit1 = reg_write & (wr_reg == rd_reg1) & (rd_reg1 != 0).
  - fwd_hit2 is the same for rd_reg2.
  - Consumers mux in wr_data when a hit flag is high.
- Ordering: at most one write per cycle, committed in grant order. Two requests to the same address commit in grant order; the later one wins.

## Timing
- Reset (synchronous, highest priority) clears: reg_write=0, wr_reg=0, wr_data=0, rr_ptr=0.
- While reset is high, req_ready is forced to 0 and fwd_hit1/2 = 0.
- Latency: transfer at edge t means the outputs are valid in cycle t+1. With stall low, the register file is written at edge t+1.
- Throughput: one write per cycle when stall is low. Back-to-back grants are allowed because the slot frees on commit.
- Starvation bound: a continuously valid requester is granted within NUM_REQ non-stalled grant opportunities.
- Reset mid-operation: a pending slot is discarded (write lost). rr_ptr returns to 0.
- rr_ptr wrap: after a grant to NUM_REQ-1, rr_ptr = 0.
- stall toggling each cycle: each slot write commits exactly once, on its first non-stall cycle. It is never duplicated.

## Test plan
- Reset, then req_valid=3'b001 with addr 5, data 0xDEADBEEF at cycle 0 -> req_ready=3'b001 in cycle 0; cycle 1 reg_write=1, wr_reg=5, wr_data=0xDEADBEEF; cycle 2 reg_write=0.
- All three requesters valid continuously (addrs 1, 2, 3), stall low -> grants 0,1,2,0,1,2 on consecutive cycles; reg_write stays high; wr_reg sequence 1,2,3,1,2,3.
- Slot holding addr 7 while stall is high for 4 cycles and requesters 1 and 2 are valid -> req_ready=0 and wr_reg=7 held all 4 cycles. After stall falls: the addr-7 commit and the grant to requester 1 (rr_ptr=1) happen on the same edge.
- Requester 0 valid with addr 0, data 0x1234 -> req_ready[0]=1 (consumed); reg_write stays 0; rr_ptr advances to 1.
- Slot holding addr 9 with rd_reg1=9, rd_reg2=0 -> fwd_hit1=1, fwd_hit2=0. With rd_reg1=0 and wr_reg=0 never loaded -> fwd_hit1=0.
- Reset asserted one cycle after a grant to requester 2 -> next cycle reg_write=0, wr_reg=0, wr_data=0. First grant after reset goes to the lowest valid index starting from 0.
